// File: rtl/fifo_stream_writer.sv
// rtl/fifo_stream_writer.sv - buffers a valid/ready word stream and issues Avalon-MM writes with status counters
module fifo_stream_writer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic        wrclock,
  input  logic        reset,
  input  logic        enable,
  input  logic        clear_status,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic        avm_waitrequest,
  output logic [31:0] words_written,
  output logic        stall_timeout,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL   = CW'(DEPTH);
  localparam logic [15:0]   TO_MAX = 16'(TIMEOUT);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t        state, state_next;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [15:0]   stall_cnt;
  logic          push, pop, complete, stall;

  // in_ready depends only on the occupancy register, never on waitrequest
  assign in_ready  = (count != FULL);
  assign push      = in_valid && in_ready;
  assign avm_write = (state == ISSUE);
  assign stall     = avm_write && avm_waitrequest;
  assign busy      = (count != '0) || avm_write;

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (enable && count != '0) begin
          pop        = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (!avm_waitrequest) begin
          complete = 1'b1;
          if (enable && count != '0) pop = 1'b1;
          else                       state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge wrclock) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge wrclock) begin
    if (reset) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      avm_writedata <= '0;
    end else begin
      state <= state_next;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr        <= rd_ptr + AW'(1);
        avm_writedata <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Status: clear_status wins over a same-cycle completion or stall
  always_ff @(posedge wrclock) begin
    if (reset) begin
      words_written <= '0;
      stall_cnt     <= '0;
      stall_timeout <= 1'b0;
    end else begin
      if (clear_status)  words_written <= '0;
      else if (complete) words_written <= words_written + 32'd1;

      if (!stall)                 stall_cnt <= '0;
      else if (stall_cnt != TO_MAX) stall_cnt <= stall_cnt + 16'd1;

      if (clear_status)                                stall_timeout <= 1'b0;
      else if (stall && stall_cnt >= TO_MAX - 16'd1)   stall_timeout <= 1'b1;
    end
  end

endmodule
